// File: rtl/rs_alu_pool.sv
// rs_alu_pool: shared-pool ALU reservation station.
//
// Holds up to DEPTH instructions from the dispatcher, wakes their operands
// by snooping CDB_N result buses, and issues the oldest ready entry into a
// registered valid/ready output stage feeding one ALU.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   flush               discard all entries and the output register
//   alloc_*             dispatcher allocation port (valid/ready + fields)
//   cdb_valid/tag/data  packed result buses, bus 0 in the LSBs
//   issue_*             registered issue port to the ALU (valid/ready + fields)
//   occupancy           number of busy entries
//
// Build option:
//   RS_ALU_WAKEUP_FWD_EN  when defined, an entry whose locked operands all
//                         match a valid CDB tag this cycle may issue at that
//                         same edge, with the CDB data captured directly.
module rs_alu_pool #(
  parameter int DEPTH    = 4,
  parameter int CDB_N    = 3,
  parameter int TAG_W    = 5,
  parameter int UNLOCKED = 0,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int OP_W     = 6,
  parameter int RADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [ADDR_W-1:0]         alloc_pc,
  input  logic [OP_W-1:0]           alloc_op,
  input  logic [TAG_W-1:0]          alloc_tagx,
  input  logic [TAG_W-1:0]          alloc_tagy,
  input  logic [TAG_W-1:0]          alloc_tagw,
  input  logic [DATA_W-1:0]         alloc_datax,
  input  logic [DATA_W-1:0]         alloc_datay,
  input  logic [RADDR_W-1:0]        alloc_target,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [ADDR_W-1:0]         issue_pc,
  output logic [OP_W-1:0]           issue_op,
  output logic [DATA_W-1:0]         issue_datax,
  output logic [DATA_W-1:0]         issue_datay,
  output logic [TAG_W-1:0]          issue_tagw,
  output logic [RADDR_W-1:0]        issue_target,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(UNLOCKED);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [OP_W-1:0]    op;
    logic [TAG_W-1:0]   tagx;
    logic [TAG_W-1:0]   tagy;
    logic [TAG_W-1:0]   tagw;
    logic [DATA_W-1:0]  datax;
    logic [DATA_W-1:0]  datay;
    logic [RADDR_W-1:0] target;
    logic [CNT_W-1:0]   rank;   // 0 = oldest
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } snoop_t;

  // Lowest-index valid bus carrying `tag` wins; scanning downward lets the
  // last (lowest) match overwrite any higher one.
  function automatic snoop_t snoop(input logic [TAG_W-1:0] tag);
    snoop_t s;
    s = '0;
    if (tag != TAG_FREE) begin
      for (int b = CDB_N - 1; b >= 0; b--) begin
        if (cdb_valid[b] && cdb_tag[b*TAG_W +: TAG_W] == tag) begin
          s.hit  = 1'b1;
          s.data = cdb_data[b*DATA_W +: DATA_W];
        end
      end
    end
    return s;
  endfunction

  entry_t            ent_q  [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  snoop_t            sx     [DEPTH];
  snoop_t            sy     [DEPTH];
  logic [DATA_W-1:0] cur_x  [DEPTH];
  logic [DATA_W-1:0] cur_y  [DEPTH];
  logic [DEPTH-1:0]  elig;
  snoop_t            ax, ay;
  logic [CNT_W-1:0]  occ;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  sel_rank;
  logic              do_issue;
  logic              do_alloc;
  logic [CNT_W-1:0]  alloc_rank;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    occ        = '0;
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_rank   = '0;
    elig       = '0;
    ax         = snoop(alloc_tagx);
    ay         = snoop(alloc_tagy);
    for (int i = 0; i < DEPTH; i++) begin
      sx[i]    = snoop(ent_q[i].tagx);
      sy[i]    = snoop(ent_q[i].tagy);
      // Operand value as it will be after this edge's wake-up.
      cur_x[i] = sx[i].hit ? sx[i].data : ent_q[i].datax;
      cur_y[i] = sy[i].hit ? sy[i].data : ent_q[i].datay;
      occ      = occ + CNT_W'(busy_q[i]);
`ifdef RS_ALU_WAKEUP_FWD_EN
      elig[i]  = busy_q[i] && (ent_q[i].tagx == TAG_FREE || sx[i].hit)
                           && (ent_q[i].tagy == TAG_FREE || sy[i].hit);
`else
      elig[i]  = busy_q[i] && ent_q[i].tagx == TAG_FREE
                           && ent_q[i].tagy == TAG_FREE;
`endif
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (elig[i] && (!sel_found || ent_q[i].rank < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = ent_q[i].rank;
      end
    end
  end

  assign occupancy   = occ;
  assign alloc_ready = rdy && (occ != CNT_W'(DEPTH));
  assign do_issue    = rdy && sel_found && (!issue_valid || issue_ready);
  assign do_alloc    = alloc_valid && alloc_ready;
  // A same-cycle departure shrinks the queue the new entry joins.
  assign alloc_rank  = occ - CNT_W'(do_issue);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // entry sees the pre-edge values of its neighbours and the select logic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: the entry array is reset in full (tags unlocked, data zeroed)
      // rather than only the busy bits, so a fresh pool is fully defined.
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]      <= '0;
        ent_q[i].tagx <= TAG_FREE;
        ent_q[i].tagy <= TAG_FREE;
      end
      issue_valid  <= 1'b0;
      issue_pc     <= '0;
      issue_op     <= '0;
      issue_datax  <= '0;
      issue_datay  <= '0;
      issue_tagw   <= '0;
      issue_target <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_issue && sel_idx == IDX_W'(i)) begin
          busy_q[i] <= 1'b0;
        end else if (busy_q[i]) begin
          if (sx[i].hit) begin
            ent_q[i].tagx  <= TAG_FREE;
            ent_q[i].datax <= sx[i].data;
          end
          if (sy[i].hit) begin
            ent_q[i].tagy  <= TAG_FREE;
            ent_q[i].datay <= sy[i].data;
          end
          if (do_issue && ent_q[i].rank > sel_rank)
            ent_q[i].rank <= ent_q[i].rank - 1'b1;
        end
        // The free slot is never the selected one, so no conflict above.
        if (do_alloc && free_idx == IDX_W'(i)) begin
          busy_q[i]       <= 1'b1;
          ent_q[i].pc     <= alloc_pc;
          ent_q[i].op     <= alloc_op;
          ent_q[i].tagw   <= alloc_tagw;
          ent_q[i].target <= alloc_target;
          ent_q[i].rank   <= alloc_rank;
          ent_q[i].tagx   <= ax.hit ? TAG_FREE : alloc_tagx;
          ent_q[i].datax  <= ax.hit ? ax.data  : alloc_datax;
          ent_q[i].tagy   <= ay.hit ? TAG_FREE : alloc_tagy;
          ent_q[i].datay  <= ay.hit ? ay.data  : alloc_datay;
        end
      end

      if (do_issue) begin
        issue_valid  <= 1'b1;
        issue_pc     <= ent_q[sel_idx].pc;
        issue_op     <= ent_q[sel_idx].op;
        issue_datax  <= cur_x[sel_idx];
        issue_datay  <= cur_y[sel_idx];
        issue_tagw   <= ent_q[sel_idx].tagw;
        issue_target <= ent_q[sel_idx].target;
      end else if (issue_valid && issue_ready) begin
        issue_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_pool.sv
// Directed testbench for rs_alu_pool in its default configuration
// (DEPTH=4, CDB_N=3, TAG_W=5, UNLOCKED=0, DATA_W=32).
module tb_rs_alu_pool;

  localparam int DEPTH  = 4;
  localparam int CDB_N  = 3;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    rst, rdy, flush;
  logic                    alloc_valid, alloc_ready;
  logic [31:0]             alloc_pc;
  logic [5:0]              alloc_op;
  logic [TAG_W-1:0]        alloc_tagx, alloc_tagy, alloc_tagw;
  logic [DATA_W-1:0]       alloc_datax, alloc_datay;
  logic [4:0]              alloc_target;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*DATA_W-1:0] cdb_data;
  logic                    issue_valid, issue_ready;
  logic [31:0]             issue_pc;
  logic [5:0]              issue_op;
  logic [DATA_W-1:0]       issue_datax, issue_datay;
  logic [TAG_W-1:0]        issue_tagw;
  logic [4:0]              issue_target;
  logic [2:0]              occupancy;

  int tests  = 0;
  int errors = 0;

  rs_alu_pool dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_op(alloc_op),
    .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy), .alloc_tagw(alloc_tagw),
    .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
    .alloc_target(alloc_target),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_op(issue_op),
    .issue_datax(issue_datax), .issue_datay(issue_datay),
    .issue_tagw(issue_tagw), .issue_target(issue_target),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cdb();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  task automatic set_cdb(input int bus, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] data);
    cdb_valid[bus]                 = 1'b1;
    cdb_tag[bus*TAG_W +: TAG_W]    = tag;
    cdb_data[bus*DATA_W +: DATA_W] = data;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [TAG_W-1:0] tx,
                       input logic [TAG_W-1:0] ty, input logic [31:0] dx,
                       input logic [31:0] dy);
    alloc_valid  = 1'b1;
    alloc_pc     = pc;
    alloc_tagx   = tx;
    alloc_tagy   = ty;
    alloc_datax  = dx;
    alloc_datay  = dy;
    alloc_op     = pc[5:0];
    alloc_tagw   = 5'd31;
    alloc_target = 5'd3;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [TAG_W-1:0] tx,
                       input logic [TAG_W-1:0] ty, input logic [31:0] dx,
                       input logic [31:0] dy);
    offer(pc, tx, ty, dx, dy);
    step();
    alloc_valid = 1'b0;
  endtask

  // Leaves 3 busy entries and a held output (issue_ready must be 0).
  task automatic fill_three();
    for (int k = 0; k < 4; k++) alloc(32'h500 + 32'(k), 5'd0, 5'd0, 32'(k), 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; issue_ready = 1'b1;
    alloc_valid = 1'b0; offer(0, 0, 0, 0, 0); alloc_valid = 1'b0;
    clear_cdb();
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_issue_pc", issue_pc, 0);

    // Basic alloc with both operands unlocked: issue after 2 edges.
    alloc(32'h100, 0, 0, 3, 4);
    check("basic_occ_e1", occupancy, 1);
    check("basic_valid_e1", issue_valid, 0);
    step();
    check("basic_valid_e2", issue_valid, 1);
    check("basic_pc", issue_pc, 32'h100);
    check("basic_datax", issue_datax, 3);
    check("basic_datay", issue_datay, 4);
    check("basic_tagw", issue_tagw, 31);
    check("basic_occ_e2", occupancy, 0);
    step();
    check("basic_drain", issue_valid, 0);

    // Fill with locked tagx=5, reject a 5th, wake on bus 2.
    for (int k = 0; k < DEPTH; k++) alloc(32'h200 + 32'(4 * k), 5'd5, 0, 32'(k), 32'(k));
    check("full_occ", occupancy, 4);
    check("full_alloc_ready", alloc_ready, 0);
    offer(32'h2FF, 0, 0, 0, 0);
    step();
    alloc_valid = 1'b0;
    check("full_reject_occ", occupancy, 4);
    check("full_no_issue", issue_valid, 0);
    set_cdb(2, 5'd5, 32'h55);
    step();
    clear_cdb();
    check("wake_not_yet", issue_valid, 0);
    for (int k = 0; k < DEPTH; k++) begin
      step();
      check("order_valid", issue_valid, 1);
      check("order_pc", issue_pc, 32'h200 + 32'(4 * k));
      check("order_datax", issue_datax, 32'h55);
      check("order_datay", issue_datay, 32'(k));
      check("order_occ", occupancy, 64'(3 - k));
    end
    step();
    check("order_drain", issue_valid, 0);

    // Same-cycle wake-up at allocation.
    offer(32'h300, 0, 5'd7, 1, 0);
    set_cdb(0, 5'd7, 32'hAB);
    step();
    alloc_valid = 1'b0;
    clear_cdb();
    step();
    check("alloc_wake_valid", issue_valid, 1);
    check("alloc_wake_datay", issue_datay, 32'hAB);
    check("alloc_wake_datax", issue_datax, 1);
    step();

    // Younger ready entry bypasses an older locked one.
    alloc(32'h340, 5'd3, 0, 0, 0);
    alloc(32'h344, 0, 0, 0, 0);
    step();
    check("bypass_pc", issue_pc, 32'h344);
    set_cdb(1, 5'd3, 32'h33);
    step();
    clear_cdb();
    step();
    check("bypass_old_pc", issue_pc, 32'h340);
    check("bypass_old_datax", issue_datax, 32'h33);
    step();

    // Back-pressure: output held stable.
    issue_ready = 1'b0;
    alloc(32'h400, 0, 0, 32'hA0, 0);
    alloc(32'h404, 0, 0, 32'hA4, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_valid", issue_valid, 1);
      check("hold_pc", issue_pc, 32'h400);
      check("hold_datax", issue_datax, 32'hA0);
      check("hold_occ", occupancy, 1);
    end
    issue_ready = 1'b1;
    step();
    check("release_pc", issue_pc, 32'h404);
    check("release_occ", occupancy, 0);
    step();
    check("release_drain", issue_valid, 0);

    // Flush with 3 busy entries and a held output; same-cycle alloc dropped.
    issue_ready = 1'b0;
    fill_three();
    check("pre_flush_occ", occupancy, 3);
    check("pre_flush_valid", issue_valid, 1);
    flush = 1'b1;
    offer(32'h5FF, 0, 0, 0, 0);
    step();
    flush = 1'b0;
    alloc_valid = 1'b0;
    check("flush_valid", issue_valid, 0);
    check("flush_occ", occupancy, 0);
    check("flush_pc", issue_pc, 0);
    step();
    check("flush_alloc_dropped", occupancy, 0);

    fill_three();
    check("pre_rst_occ", occupancy, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_valid", issue_valid, 0);
    check("midrst_occ", occupancy, 0);
    check("midrst_datax", issue_datax, 0);
    check("midrst_alloc_ready", alloc_ready, 1);
    issue_ready = 1'b1;

    // rdy low freezes state through a broadcast; lowest bus wins later.
    alloc(32'h600, 5'd9, 0, 0, 0);
    rdy = 1'b0;
    set_cdb(1, 5'd9, 32'h99);
    set_cdb(2, 5'd9, 32'h77);
    for (int k = 0; k < 3; k++) begin
      step();
      check("frozen_alloc_ready", alloc_ready, 0);
      check("frozen_occ", occupancy, 1);
      check("frozen_valid", issue_valid, 0);
    end
    rdy = 1'b1;
    step();
    clear_cdb();
    check("unfrozen_wake_no_issue", issue_valid, 0);
    step();
    check("unfrozen_valid", issue_valid, 1);
    check("unfrozen_pc", issue_pc, 32'h600);
    check("unfrozen_datax", issue_datax, 32'h99);
    step();
    check("final_drain", issue_valid, 0);
    check("final_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
